// File: rtl/bitwise_serial_unit.sv
// bitwise_serial_unit: multi-cycle bitwise unit, one SLICE-bit slice per clock, LSB slice first.
// Optional BITWISE_SERIAL_INVERT_EN adds an inv input that inverts every result slice.
module bitwise_serial_unit #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef BITWISE_SERIAL_INVERT_EN
   input  logic             inv,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             zero
);
   localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (WIDTH < 1 || SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_params
      $error("bitwise_serial_unit: WIDTH must be >=1 and a multiple of SLICE");
   end

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
   logic [1:0]       op_r;
   logic             zero_r, accept, last;
   logic [SLICE-1:0] sa, sb, f, fs;
`ifdef BITWISE_SERIAL_INVERT_EN
   logic             inv_r;
`endif

   always_comb begin
      sa = a_r[SLICE-1:0];
      sb = b_r[SLICE-1:0];
      f = (op_r == 2'd0) ? sb :
          (op_r == 2'd1) ? (sa | sb) :
          (op_r == 2'd2) ? (sa & sb) : (sa ^ sb);
`ifdef BITWISE_SERIAL_INVERT_EN
      fs = f ^ {SLICE{inv_r}};
`else
      fs = f;
`endif
      // result is cleared at accept, so OR-ing the new slice into place is enough
      res_nxt = res | (WIDTH'(fs) << (cnt * SLICE));
      last = (cnt == CW'(N - 1));
      in_ready = (state == IDLE) || (state == DONE && out_ready);
      accept = in_valid && in_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         op_r   <= '0;
         res    <= '0;
         zero_r <= 1'b0;
`ifdef BITWISE_SERIAL_INVERT_EN
         inv_r  <= 1'b0;
`endif
      end else if (accept) begin
         state  <= BUSY;
         cnt    <= '0;
         a_r    <= a;
         b_r    <= b;
         op_r   <= op;
         res    <= '0;
         zero_r <= 1'b0;
`ifdef BITWISE_SERIAL_INVERT_EN
         inv_r  <= inv;
`endif
      end else if (state == BUSY) begin
         res <= res_nxt;
         a_r <= a_r >> SLICE;
         b_r <= b_r >> SLICE;
         cnt <= cnt + 1'b1;
         if (last) begin
            state  <= DONE;
            zero_r <= ~|res_nxt;
         end
      end else if (state == DONE && out_ready) begin
         state  <= IDLE;
         zero_r <= 1'b0;
      end
   end

   assign out_valid = (state == DONE);
   assign q         = res;
   assign zero      = zero_r;
endmodule

// File: tb/tb_bitwise_serial_unit.sv
// tb_bitwise_serial_unit: scoreboard bench with a reference model for bitwise_serial_unit.
module tb_bitwise_serial_unit;
   localparam int N = 8;

   typedef struct {
      logic [7:0] q;
      logic       z;
      int         acc;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, rand_ready = 1'b0;
   logic [1:0] op = '0;
   logic [7:0] a = '0, b = '0;
   logic in_ready, out_valid, zero;
   logic [7:0] q;

   logic [1:0] op16 = 2'd2;
   logic [15:0] a16 = '0, b16 = '0;
   logic iv16 = 1'b0;
   logic ir4, ov4, z4, ir1, ov1, z1;
   logic [15:0] q4, q1;

   int cyc = 0, errors = 0, checks = 0;
   exp_t sb[$];
   exp_t cur;
   logic prev_ov = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitwise_serial_unit #(.WIDTH(8), .SLICE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .zero(zero));
   bitwise_serial_unit #(.WIDTH(16), .SLICE(4)) u16_4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir4), .op(op16),
      .a(a16), .b(b16), .out_valid(ov4), .out_ready(1'b1), .q(q4), .zero(z4));
   bitwise_serial_unit #(.WIDTH(16), .SLICE(16)) u16_16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir1), .op(op16),
      .a(a16), .b(b16), .out_valid(ov1), .out_ready(1'b1), .q(q1), .zero(z1));

   function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         2'd0:    return y;
         2'd1:    return x | y;
         2'd2:    return x & y;
         default: return x ^ y;
      endcase
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // monitor: new results are popped and compared; held results must stay put
   always @(negedge clk) begin
      if (!rst_n) prev_ov <= 1'b0;
      else begin
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) check("unexpected_result", 1, 0);
            else begin
               cur = sb.pop_front();
               check("q", q, cur.q);
               check("zero", zero, cur.z);
               check("latency", cyc - cur.acc, N);
            end
         end else if (out_valid) begin
            check("q_hold", q, cur.q);
            check("zero_hold", zero, cur.z);
         end else check("zero_idle", zero, 0);
         prev_ov <= out_valid;
      end
   end

   always @(negedge clk) if (rand_ready) out_ready <= 1'($urandom);

   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
      int n = 0;
      exp_t e;
      @(negedge clk);
      a = x; b = y; op = o; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      e.q = model(o, x, y);
      e.z = (e.q == 8'h00);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      int l4, l1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_q", q, 0);
      check("rst_zero", zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(8'hC5, 8'h3A, 2'(i));
         drain();
      end

      out_ready = 1'b0;
      issue(8'hF0, 8'h0F, 2'd3);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("bp_valid", out_valid, 1);
      out_ready = 1'b1;
      issue(8'hAA, 8'hAA, 2'd3);
      drain();

      issue(8'hFF, 8'hFF, 2'd2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_q", q, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(8'h5C, 8'h33, 2'd1);
      drain();

      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) issue(8'($urandom), 8'($urandom), 2'($urandom));
      rand_ready = 1'b0;
      out_ready = 1'b1;
      drain();

      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h00FF; op16 = 2'd2; iv16 = 1'b1;
      #1;
      check("p_in_ready4", ir4, 1);
      check("p_in_ready1", ir1, 1);
      @(posedge clk);
      #1;
      iv16 = 1'b0; a16 = '0; b16 = '0;
      l4 = -1; l1 = -1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (ov4 && l4 < 0) begin l4 = i; check("p_q4", q4, 16'h0034); end
         if (ov1 && l1 < 0) begin l1 = i; check("p_q1", q1, 16'h0034); end
      end
      check("p_lat4", l4, 4);
      check("p_lat1", l1, 1);
      check("p_zero4", z4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
